// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order commit queue for the out-of-order core.
// It hands out tags at dispatch, captures CDB results, answers operand tag
// queries, commits the head entry to the register file, and raises a
// one-cycle flush when a mispredicted branch commits.
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   output logic             full,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             disp_valid,
   input  logic [4:0]       disp_rd,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_val,
   input  logic             cdb_mispred,
   input  logic [XLEN-1:0]  cdb_target,
   input  logic [TAG_W-1:0] q1_tag,
   input  logic [TAG_W-1:0] q2_tag,
   output logic             q1_ready,
   output logic             q2_ready,
   output logic [XLEN-1:0]  q1_val,
   output logic [XLEN-1:0]  q2_val,
   output logic             rf_in_flag,
   output logic [4:0]       rf_in_a,
   output logic [TAG_W-1:0] rf_in_rob,
   output logic             rf_out_flag,
   output logic [4:0]       rf_out_a,
   output logic [XLEN-1:0]  rf_out_val,
   output logic [TAG_W-1:0] rf_out_rob,
   output logic             flush_out,
   output logic [XLEN-1:0]  redirect_pc
);

   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] mispred_q;
   logic [4:0]       rd_q     [DEPTH];
   logic [XLEN-1:0]  val_q    [DEPTH];
   logic [XLEN-1:0]  target_q [DEPTH];

   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;

   logic accept;
   logic commit;
   logic commit_flush;

   // Handshake decode: full uses the pre-edge count, so a slot freed by this cycle's commit is not reusable until next cycle
   always_comb begin
      full         = (count == FULL_CNT) | flush_out;
      accept       = rdy & ~rst & disp_valid & ~full;
      commit       = rdy & ~rst & busy[head] & ready[head];
      commit_flush = commit & mispred_q[head];
      alloc_tag    = tail;
      rf_in_flag   = accept & (disp_rd != 5'd0) & ~commit_flush;
      rf_in_a      = disp_rd;
      rf_in_rob    = tail;
      rf_out_flag  = commit & (rd_q[head] != 5'd0);
      rf_out_a     = rd_q[head];
      rf_out_val   = val_q[head];
      rf_out_rob   = head;
   end

   // Operand queries: a latched result wins, otherwise a CDB broadcast to the same tag is forwarded
   always_comb begin
      q1_ready = 1'b0;
      q1_val   = '0;
      q2_ready = 1'b0;
      q2_val   = '0;
      if (ready[q1_tag]) begin
         q1_ready = 1'b1;
         q1_val   = val_q[q1_tag];
      end else if (cdb_valid && (cdb_tag == q1_tag)) begin
         q1_ready = 1'b1;
         q1_val   = cdb_val;
      end
      if (ready[q2_tag]) begin
         q2_ready = 1'b1;
         q2_val   = val_q[q2_tag];
      end else if (cdb_valid && (cdb_tag == q2_tag)) begin
         q2_ready = 1'b1;
         q2_val   = cdb_val;
      end
   end

   // Queue state: a mispredicted commit wipes everything, otherwise CDB capture, dispatch and commit update independent slots
   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= '0;
         ready       <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         flush_out   <= 1'b0;
         redirect_pc <= '0;
      end else if (rdy) begin
         flush_out <= 1'b0;
         if (commit_flush) begin
            busy        <= '0;
            ready       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            flush_out   <= 1'b1;
            redirect_pc <= target_q[head];
         end else begin
            if (cdb_valid && busy[cdb_tag]) begin
               ready[cdb_tag]     <= 1'b1;
               val_q[cdb_tag]     <= cdb_val;
               mispred_q[cdb_tag] <= cdb_mispred;
               target_q[cdb_tag]  <= cdb_target;
            end
            if (accept) begin
               busy[tail]  <= 1'b1;
               ready[tail] <= 1'b0;
               rd_q[tail]  <= disp_rd;
               tail        <= tail + 1'b1;
            end
            if (commit) begin
               busy[head]  <= 1'b0;
               ready[head] <= 1'b0;
               head        <= head + 1'b1;
            end
            case ({accept, commit})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: the main thread drives vectors and
// records expected commits; a negedge monitor pops and compares them.
module tb_reorder_buffer;

   localparam int DEPTH = 16;
   localparam int TAG_W = 4;
   localparam int XLEN  = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             rdy;
   logic             full;
   logic [TAG_W-1:0] alloc_tag;
   logic             disp_valid;
   logic [4:0]       disp_rd;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_val;
   logic             cdb_mispred;
   logic [XLEN-1:0]  cdb_target;
   logic [TAG_W-1:0] q1_tag;
   logic [TAG_W-1:0] q2_tag;
   logic             q1_ready;
   logic             q2_ready;
   logic [XLEN-1:0]  q1_val;
   logic [XLEN-1:0]  q2_val;
   logic             rf_in_flag;
   logic [4:0]       rf_in_a;
   logic [TAG_W-1:0] rf_in_rob;
   logic             rf_out_flag;
   logic [4:0]       rf_out_a;
   logic [XLEN-1:0]  rf_out_val;
   logic [TAG_W-1:0] rf_out_rob;
   logic             flush_out;
   logic [XLEN-1:0]  redirect_pc;

   typedef struct {
      logic [4:0]       rd;
      logic [TAG_W-1:0] tag;
   } commit_t;

   commit_t         expQ [$];
   commit_t         monEntry;
   logic [XLEN-1:0] expVal [DEPTH];
   int              checks   = 0;
   int              failures = 0;

   always #5 clk = ~clk;

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .full(full), .alloc_tag(alloc_tag),
      .disp_valid(disp_valid), .disp_rd(disp_rd),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
      .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_val(q1_val), .q2_val(q2_val),
      .rf_in_flag(rf_in_flag), .rf_in_a(rf_in_a), .rf_in_rob(rf_in_rob),
      .rf_out_flag(rf_out_flag), .rf_out_a(rf_out_a), .rf_out_val(rf_out_val),
      .rf_out_rob(rf_out_rob), .flush_out(flush_out), .redirect_pc(redirect_pc)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic dv, input logic [4:0] rd, input logic cv,
                                input logic [TAG_W-1:0] ctag, input logic [XLEN-1:0] cval,
                                input logic cmis, input logic [XLEN-1:0] ctgt);
      disp_valid  = dv;
      disp_rd     = rd;
      cdb_valid   = cv;
      cdb_tag     = ctag;
      cdb_val     = cval;
      cdb_mispred = cmis;
      cdb_target  = ctgt;
      if (cv) expVal[ctag] = cval;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatchCheck(input logic [4:0] rd, input logic [TAG_W-1:0] tag);
      checkOutput("disp_flag", 32'(rf_in_flag), 32'd1);
      checkOutput("disp_rd", 32'(rf_in_a), 32'(rd));
      checkOutput("disp_tag", 32'(rf_in_rob), 32'(tag));
      expQ.push_back('{rd: rd, tag: tag});
   endtask

   task automatic resetDut();
      rst = 1'b1;
      idle();
      nextCycle();
      rst = 1'b0;
      expQ.delete();
   endtask

   // Commit monitor: every register-file write must match the oldest outstanding dispatch
   always @(negedge clk) begin
      if (rf_out_flag) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_commit: got rob 0x%0h expected no commit", rf_out_rob);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("commit_tag", 32'(rf_out_rob), 32'(monEntry.tag));
            checkOutput("commit_rd", 32'(rf_out_a), 32'(monEntry.rd));
            checkOutput("commit_val", rf_out_val, expVal[monEntry.tag]);
         end
      end
   end

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] timeout");
   end

   // Directed scenario sequence
   initial begin
      for (int i = 0; i < DEPTH; i++) expVal[i] = '0;
      rst    = 1'b1;
      rdy    = 1'b1;
      q1_tag = '0;
      q2_tag = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_full", 32'(full), 32'd0);
      checkOutput("reset_alloc_tag", 32'(alloc_tag), 32'd0);
      checkOutput("reset_rf_in_flag", 32'(rf_in_flag), 32'd0);
      checkOutput("reset_rf_out_flag", 32'(rf_out_flag), 32'd0);
      checkOutput("reset_q1_ready", 32'(q1_ready), 32'd0);
      checkOutput("reset_flush", 32'(flush_out), 32'd0);
      checkOutput("reset_redirect", redirect_pc, 32'd0);
      nextCycle();

      $display("[TB] dispatch rd 5,6,7");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'(5 + i), 1'b0, '0, '0, 1'b0, '0);
         @(negedge clk);
         dispatchCheck(5'(5 + i), TAG_W'(i));
         nextCycle();
      end
      idle();
      @(negedge clk);
      checkOutput("t1_alloc_tag", 32'(alloc_tag), 32'd3);
      checkOutput("t1_full", 32'(full), 32'd0);
      nextCycle();

      $display("[TB] out-of-order results, in-order commit");
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd2, 32'h30, 1'b0, '0);
      @(negedge clk);
      checkOutput("t2_c1_no_commit", 32'(rf_out_flag), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h10, 1'b0, '0);
      @(negedge clk);
      checkOutput("t2_c2_no_commit", 32'(rf_out_flag), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'h20, 1'b0, '0);
      @(negedge clk);
      checkOutput("t2_c3_commit", 32'(rf_out_flag), 32'd1);
      checkOutput("t2_c3_rob", 32'(rf_out_rob), 32'd0);
      nextCycle();
      idle();
      @(negedge clk);
      checkOutput("t2_c4_commit", 32'(rf_out_flag), 32'd1);
      checkOutput("t2_c4_rob", 32'(rf_out_rob), 32'd1);
      nextCycle();
      @(negedge clk);
      checkOutput("t2_c5_commit", 32'(rf_out_flag), 32'd1);
      checkOutput("t2_c5_rob", 32'(rf_out_rob), 32'd2);
      nextCycle();
      @(negedge clk);
      checkOutput("t2_c6_idle", 32'(rf_out_flag), 32'd0);
      checkOutput("t2_drained", 32'(expQ.size()), 32'd0);
      nextCycle();

      $display("[TB] fill to full and wrap");
      resetDut();
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 1'b0, '0, '0, 1'b0, '0);
         @(negedge clk);
         dispatchCheck(5'(i + 1), TAG_W'(i));
         nextCycle();
      end
      applyStimulus(1'b1, 5'd20, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t3_full", 32'(full), 32'd1);
      checkOutput("t3_17th_rejected", 32'(rf_in_flag), 32'd0);
      checkOutput("t3_alloc_wrapped", 32'(alloc_tag), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h55, 1'b0, '0);
      @(negedge clk);
      checkOutput("t3_w1_no_commit", 32'(rf_out_flag), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 5'd21, 1'b1, 4'd1, 32'h66, 1'b0, '0);
      @(negedge clk);
      checkOutput("t3_w2_full", 32'(full), 32'd1);
      checkOutput("t3_w2_no_disp", 32'(rf_in_flag), 32'd0);
      checkOutput("t3_w2_commit", 32'(rf_out_flag), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 5'd21, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t3_w3_not_full", 32'(full), 32'd0);
      dispatchCheck(5'd21, 4'd0);
      checkOutput("t3_w3_commit", 32'(rf_out_flag), 32'd1);
      nextCycle();
      applyStimulus(1'b1, 5'd22, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      dispatchCheck(5'd22, 4'd1);
      checkOutput("t3_w4_no_commit", 32'(rf_out_flag), 32'd0);
      nextCycle();
      idle();
      @(negedge clk);
      checkOutput("t3_w5_full_again", 32'(full), 32'd1);
      checkOutput("t3_w5_alloc_tag", 32'(alloc_tag), 32'd2);
      nextCycle();

      $display("[TB] operand query bypass");
      q1_tag = 4'd3;
      q2_tag = 4'd4;
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd3, 32'hAB, 1'b0, '0);
      @(negedge clk);
      checkOutput("t4_bypass_ready", 32'(q1_ready), 32'd1);
      checkOutput("t4_bypass_val", q1_val, 32'hAB);
      checkOutput("t4_q2_not_ready", 32'(q2_ready), 32'd0);
      checkOutput("t4_q2_val_zero", q2_val, 32'd0);
      nextCycle();
      idle();
      @(negedge clk);
      checkOutput("t4_latched_ready", 32'(q1_ready), 32'd1);
      checkOutput("t4_latched_val", q1_val, 32'hAB);
      nextCycle();

      $display("[TB] mispredict flush");
      resetDut();
      q1_tag = 4'd1;
      q2_tag = 4'd0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(8 + i), 1'b0, '0, '0, 1'b0, '0);
         @(negedge clk);
         dispatchCheck(5'(8 + i), TAG_W'(i));
         nextCycle();
      end
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd1, 32'h99, 1'b0, '0);
      @(negedge clk);
      checkOutput("t5_no_commit_a", 32'(rf_out_flag), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h77, 1'b1, 32'h1000);
      @(negedge clk);
      checkOutput("t5_no_commit_b", 32'(rf_out_flag), 32'd0);
      nextCycle();
      applyStimulus(1'b1, 5'd12, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t5_mispred_commit", 32'(rf_out_flag), 32'd1);
      checkOutput("t5_mispred_rob", 32'(rf_out_rob), 32'd0);
      checkOutput("t5_disp_dropped", 32'(rf_in_flag), 32'd0);
      checkOutput("t5_flush_not_yet", 32'(flush_out), 32'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("t5_flush", 32'(flush_out), 32'd1);
      checkOutput("t5_redirect", redirect_pc, 32'h1000);
      checkOutput("t5_full_in_flush", 32'(full), 32'd1);
      checkOutput("t5_alloc_tag", 32'(alloc_tag), 32'd0);
      checkOutput("t5_no_disp_in_flush", 32'(rf_in_flag), 32'd0);
      checkOutput("t5_no_commit_in_flush", 32'(rf_out_flag), 32'd0);
      checkOutput("t5_entries_cleared", 32'(q1_ready), 32'd0);
      expQ.delete();
      nextCycle();
      idle();
      @(negedge clk);
      checkOutput("t5_flush_cleared", 32'(flush_out), 32'd0);
      checkOutput("t5_not_full", 32'(full), 32'd0);
      checkOutput("t5_alloc_tag_after", 32'(alloc_tag), 32'd0);
      nextCycle();

      $display("[TB] rdy hold");
      applyStimulus(1'b1, 5'd13, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      dispatchCheck(5'd13, 4'd0);
      nextCycle();
      applyStimulus(1'b0, 5'd0, 1'b1, 4'd0, 32'h42, 1'b0, '0);
      @(negedge clk);
      checkOutput("t6_no_commit_yet", 32'(rf_out_flag), 32'd0);
      nextCycle();
      rdy = 1'b0;
      applyStimulus(1'b1, 5'd14, 1'b0, '0, '0, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("t6_hold_no_commit", 32'(rf_out_flag), 32'd0);
         checkOutput("t6_hold_no_disp", 32'(rf_in_flag), 32'd0);
         checkOutput("t6_hold_alloc_tag", 32'(alloc_tag), 32'd1);
         nextCycle();
      end
      rdy = 1'b1;
      idle();
      @(negedge clk);
      checkOutput("t6_resume_commit", 32'(rf_out_flag), 32'd1);
      checkOutput("t6_resume_rob", 32'(rf_out_rob), 32'd0);
      nextCycle();
      @(negedge clk);
      checkOutput("t6_after_commit", 32'(rf_out_flag), 32'd0);
      checkOutput("t6_alloc_tag", 32'(alloc_tag), 32'd1);
      checkOutput("t6_drained", 32'(expQ.size()), 32'd0);
      nextCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
